mole_scheduler: RTL and testbench

- Sequences the 9-hole mole map for the whack-a-mole game: decides when and where moles appear, how long they stay up, and resolves keyboard hits against the live map.
- Sits between the keyboard one-pulse decoder and score/state control.
- Drives the 9-bit map consumed by display and LEDs.
- Reports per-event pulses (hit, wrong hit, expiry) so game control can update score and lives.

---
 rtl/mole_scheduler.sv | 156 +++++++++++++++
 tb/tb_mole_scheduler.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mole_scheduler.sv
// rtl/mole_scheduler.sv - whack-a-mole scheduler: spawns, ages and hit-resolves moles on a 9-hole map
module mole_scheduler #(
    parameter int unsigned TICK_DIV    = 1_000_000,
    parameter int unsigned SPAWN_TICKS = 50,
    parameter int unsigned LIFE_TICKS  = 100,
    parameter int unsigned MAX_ACTIVE  = 3,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       hit_valid,
    input  logic [3:0] hit_idx,
    output logic [8:0] map,
    output logic [3:0] active_cnt,
    output logic       hit_ok,
    output logic       hit_bad,
    output logic       expired,
    output logic       state
);
    localparam int TICK_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SPAWN_W = (SPAWN_TICKS > 1) ? $clog2(SPAWN_TICKS) : 1;
    localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(TICK_DIV - 1);
    localparam logic [SPAWN_W-1:0] SPAWN_LAST = SPAWN_W'(SPAWN_TICKS - 1);
    localparam logic [6:0]         LIFE_LAST  = 7'(LIFE_TICKS - 1);
    localparam logic [3:0]         MAX_CNT    = 4'(MAX_ACTIVE);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t             state_q, state_d;
    logic [TICK_W-1:0]  tick_q, tick_d;
    logic [SPAWN_W-1:0] spawn_q, spawn_d;
    logic [15:0]        lfsr_q, lfsr_d;
    logic [8:0]         map_q, map_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [6:0]         life_q [9];
    logic [6:0]         life_d [9];
    logic               hit_ok_q, hit_ok_d;
    logic               hit_bad_q, hit_bad_d;
    logic               exp_q, exp_d;

    logic               tick;
    logic [3:0]         cand;
    logic [3:0]         slot;
    logic               slot_found;
    logic [4:0]         probe;

    // First empty hole scanning upward from the candidate; lowest offset wins.
    always_comb begin
        cand       = (lfsr_q[3:0] >= 4'd9) ? (lfsr_q[3:0] - 4'd9) : lfsr_q[3:0];
        slot       = 4'd0;
        slot_found = 1'b0;
        probe      = 5'd0;
        for (int k = 8; k >= 0; k--) begin
            probe = 5'(cand) + 5'(k);
            if (probe >= 5'd9) probe = probe - 5'd9;
            if (!map_q[probe[3:0]]) begin
                slot       = probe[3:0];
                slot_found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        tick_d    = tick_q;
        spawn_d   = spawn_q;
        lfsr_d    = lfsr_q;
        map_d     = map_q;
        life_d    = life_q;
        hit_ok_d  = 1'b0;
        hit_bad_d = 1'b0;
        exp_d     = 1'b0;
        tick      = 1'b0;
        case (state_q)
            IDLE: if (enable) state_d = RUN;
            RUN: begin
                lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
                if (!enable) begin
                    state_d = IDLE;
                    tick_d  = '0;
                    spawn_d = '0;
                    map_d   = '0;
                    for (int i = 0; i < 9; i++) life_d[i] = '0;
                end else begin
                    tick   = (tick_q == TICK_LAST);
                    tick_d = tick ? '0 : tick_q + 1'b1;
                    if (hit_valid && hit_idx <= 4'd8) begin
                        if (map_q[hit_idx]) begin
                            map_d[hit_idx] = 1'b0;
                            hit_ok_d       = 1'b1;
                        end else begin
                            hit_bad_d = 1'b1;
                        end
                    end
                    if (tick) begin
                        // A hole hit this cycle is already clear in map_d, so it cannot also expire.
                        for (int i = 0; i < 9; i++) begin
                            if (map_q[i] && map_d[i]) begin
                                if (life_q[i] == LIFE_LAST) begin
                                    map_d[i] = 1'b0;
                                    exp_d    = 1'b1;
                                end else begin
                                    life_d[i] = life_q[i] + 7'd1;
                                end
                            end
                        end
                        if (spawn_q != SPAWN_LAST) begin
                            spawn_d = spawn_q + 1'b1;
                        end else if (cnt_q < MAX_CNT && slot_found) begin
                            map_d[slot]  = 1'b1;
                            life_d[slot] = '0;
                            spawn_d      = '0;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        cnt_d = '0;
        for (int i = 0; i < 9; i++) cnt_d = cnt_d + 4'(map_d[i]);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            tick_q    <= '0;
            spawn_q   <= '0;
            lfsr_q    <= LFSR_SEED;
            map_q     <= '0;
            cnt_q     <= '0;
            hit_ok_q  <= 1'b0;
            hit_bad_q <= 1'b0;
            exp_q     <= 1'b0;
            for (int i = 0; i < 9; i++) life_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            tick_q    <= tick_d;
            spawn_q   <= spawn_d;
            lfsr_q    <= lfsr_d;
            map_q     <= map_d;
            cnt_q     <= cnt_d;
            hit_ok_q  <= hit_ok_d;
            hit_bad_q <= hit_bad_d;
            exp_q     <= exp_d;
            for (int i = 0; i < 9; i++) life_q[i] <= life_d[i];
        end
    end

    assign map        = map_q;
    assign active_cnt = cnt_q;
    assign hit_ok     = hit_ok_q;
    assign hit_bad    = hit_bad_q;
    assign expired    = exp_q;
    assign state      = (state_q == RUN);
endmodule

// File: tb/tb_mole_scheduler.sv
// tb/tb_mole_scheduler.sv - scoreboard bench for mole_scheduler
module tb_mole_scheduler;
    localparam int TD = 4, ST = 3, LT = 5, MA = 2, LT2 = 12;

    logic       clk = 1'b0;
    logic       rst, enable, hit_valid, enable2, hv2;
    logic [3:0] hit_idx, hi2;
    logic [8:0] map, map2;
    logic [3:0] active_cnt, active_cnt2;
    logic       hit_ok, hit_bad, expired, state;
    logic       hit_ok2, hit_bad2, expired2, state2;

    int n_checks = 0;
    int n_pass   = 0;
    logic [8:0] first_hole;

    always #5 clk = ~clk;

    mole_scheduler #(.TICK_DIV(TD), .SPAWN_TICKS(ST), .LIFE_TICKS(LT), .MAX_ACTIVE(MA),
                     .LFSR_SEED(16'hACE1)) u_dut (
        .clk(clk), .rst(rst), .enable(enable), .hit_valid(hit_valid), .hit_idx(hit_idx),
        .map(map), .active_cnt(active_cnt), .hit_ok(hit_ok), .hit_bad(hit_bad),
        .expired(expired), .state(state));

    // Longer-lived instance so that MAX_ACTIVE actually blocks spawns.
    mole_scheduler #(.TICK_DIV(TD), .SPAWN_TICKS(ST), .LIFE_TICKS(LT2), .MAX_ACTIVE(MA),
                     .LFSR_SEED(16'hACE1)) u_sat (
        .clk(clk), .rst(rst), .enable(enable2), .hit_valid(hv2), .hit_idx(hi2),
        .map(map2), .active_cnt(active_cnt2), .hit_ok(hit_ok2), .hit_bad(hit_bad2),
        .expired(expired2), .state(state2));

    // Reference model: state after each edge, outputs queued as {state,exp,bad,ok,cnt,map}.
    logic [15:0] m_lfsr = 16'hACE1;
    logic [8:0]  m_map = '0;
    int          m_tick = 0, m_spawn = 0;
    int          m_life [9];
    bit          m_run = 0, m_ok = 0, m_bad = 0, m_exp = 0;
    logic [16:0] sb[$];

    function automatic int popc(logic [8:0] v);
        int n = 0;
        for (int i = 0; i < 9; i++) n += int'(v[i]);
        return n;
    endfunction

    initial begin
        logic [8:0] pre;
        bit tk, placed;
        int c, h;
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                m_run = 0; m_map = '0; m_tick = 0; m_spawn = 0; m_lfsr = 16'hACE1;
                m_ok = 0; m_bad = 0; m_exp = 0;
                for (int i = 0; i < 9; i++) m_life[i] = 0;
                sb.delete();
            end else begin
                pre = m_map; m_ok = 0; m_bad = 0; m_exp = 0;
                if (!m_run) begin
                    m_run = enable;
                end else if (!enable) begin
                    m_run = 0; m_map = '0; m_tick = 0; m_spawn = 0;
                    m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
                end else begin
                    tk = (m_tick == TD - 1);
                    c = int'(m_lfsr[3:0]) % 9;
                    m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
                    m_tick = tk ? 0 : m_tick + 1;
                    if (hit_valid && hit_idx < 9) begin
                        if (pre[hit_idx]) begin m_map[hit_idx] = 1'b0; m_ok = 1; end
                        else m_bad = 1;
                    end
                    if (tk) begin
                        for (int i = 0; i < 9; i++) begin
                            if (pre[i] && m_map[i]) begin
                                m_life[i]++;
                                if (m_life[i] == LT) begin m_map[i] = 1'b0; m_exp = 1; end
                            end
                        end
                        if (m_spawn < ST - 1) m_spawn++;
                        else if (popc(pre) < MA) begin
                            placed = 0;
                            for (int k = 0; k < 9; k++) begin
                                h = (c + k) % 9;
                                if (!placed && !pre[h]) begin
                                    m_map[h] = 1'b1; m_life[h] = 0; m_spawn = 0; placed = 1;
                                end
                            end
                        end
                    end
                end
                sb.push_back({m_run, m_exp, m_bad, m_ok, 4'(popc(m_map)), m_map});
            end
        end
    end

    task automatic step(output logic [16:0] obs, output logic [16:0] want, output bit ok);
        @(negedge clk);
        obs = {state, expired, hit_bad, hit_ok, active_cnt, map};
        ok = (sb.size() != 0);
        want = '0;
        if (ok) want = sb.pop_front();
    endtask

    task automatic test_reset();
        logic [16:0] obs, want; bit ok;
        rst = 1'b0; enable = 1'b0; hit_valid = 1'b0; hit_idx = 4'd0;
        enable2 = 1'b0; hv2 = 1'b0; hi2 = 4'd0;
        step(obs, want, ok);
        n_checks++;
        if (obs !== 17'h0) $display("FAIL reset_values got=%h want=0", obs); else n_pass++;
        rst = 1'b1;
        step(obs, want, ok);
        n_checks++;
        if (!ok || obs !== want) $display("FAIL idle_sb got=%h want=%h", obs, want); else n_pass++;
        hit_valid = 1'b1; hit_idx = 4'd2;
        step(obs, want, ok);
        hit_valid = 1'b0;
        n_checks++;
        if (obs !== 17'h0) $display("FAIL idle_hit_ignored got=%h want=0", obs); else n_pass++;
    endtask

    task automatic test_spawn();
        logic [16:0] obs, want; bit ok;
        enable = 1'b1;
        step(obs, want, ok);
        n_checks++;
        if (obs[16] !== 1'b1 || obs[8:0] !== 9'h0) $display("FAIL run_entry got=%h want state=1 map=0", obs);
        else n_pass++;
        for (int k = 1; k <= 12; k++) begin
            step(obs, want, ok);
            n_checks++;
            if (!ok || obs !== want) $display("FAIL spawn_sb k=%0d got=%h want=%h", k, obs, want); else n_pass++;
            if (k >= 11) begin
                n_checks++;
                if (obs[12:9] !== ((k == 12) ? 4'd1 : 4'd0) || $countones(obs[8:0]) != ((k == 12) ? 1 : 0))
                    $display("FAIL first_spawn k=%0d got map=%h cnt=%0d", k, obs[8:0], obs[12:9]);
                else n_pass++;
            end
        end
        first_hole = want[8:0];
    endtask

    task automatic test_expiry();
        logic [16:0] obs, want; bit ok;
        for (int k = 1; k <= 21; k++) begin
            step(obs, want, ok);
            n_checks++;
            if (!ok || obs !== want) $display("FAIL expiry_sb k=%0d got=%h want=%h", k, obs, want); else n_pass++;
            if (k == 19) begin
                n_checks++;
                if ((obs[8:0] & first_hole) == 9'h0 || obs[15] !== 1'b0)
                    $display("FAIL expiry_early got=%h hole=%h", obs, first_hole);
                else n_pass++;
            end
            if (k == 20) begin
                n_checks++;
                if ((obs[8:0] & first_hole) != 9'h0 || obs[15] !== 1'b1 || obs[13] !== 1'b0)
                    $display("FAIL expiry_edge got=%h hole=%h want bit clear expired=1", obs, first_hole);
                else n_pass++;
            end
            if (k == 21) begin
                n_checks++;
                if (obs[15] !== 1'b0) $display("FAIL expiry_one_cycle got=%b want=0", obs[15]); else n_pass++;
            end
        end
    endtask

    task automatic test_hit();
        logic [16:0] obs, want; bit ok;
        int h = -1, e = -1;
        for (int i = 0; i < 9; i++) if (h < 0 && m_map[i]) h = i;
        n_checks++;
        if (h < 0) begin
            $display("FAIL hit_no_mole got=none want=one up");
        end else begin
            n_pass++;
            hit_valid = 1'b1; hit_idx = 4'(h);
            step(obs, want, ok);
            hit_valid = 1'b0;
            n_checks++;
            if (obs[h] !== 1'b0 || obs[13] !== 1'b1 || !ok || obs !== want)
                $display("FAIL hit_ok hole=%0d got=%h want=%h", h, obs, want);
            else n_pass++;
        end
        for (int i = 0; i < 9; i++) if (e < 0 && !m_map[(4 + i) % 9]) e = (4 + i) % 9;
        hit_valid = 1'b1; hit_idx = 4'(e);
        step(obs, want, ok);
        n_checks++;
        if (obs[14] !== 1'b1 || obs[13] !== 1'b0 || !ok || obs !== want)
            $display("FAIL hit_bad hole=%0d got=%h want=%h", e, obs, want);
        else n_pass++;
        hit_idx = 4'd12;
        step(obs, want, ok);
        hit_valid = 1'b0;
        n_checks++;
        if (obs[14:13] !== 2'b00 || !ok || obs !== want)
            $display("FAIL hit_idx12 got=%h want=%h", obs, want);
        else n_pass++;
    endtask

    task automatic test_saturation();
        logic [16:0] obs, want; bit ok;
        logic [3:0] cnt_want;
        enable2 = 1'b1;
        step(obs, want, ok);
        n_checks++;
        if (state2 !== 1'b1) $display("FAIL sat_entry got=%b want=1", state2); else n_pass++;
        for (int e = 1; e <= 70; e++) begin
            step(obs, want, ok);
            n_checks++;
            if (!ok || obs !== want) $display("FAIL run_sb e=%0d got=%h want=%h", e, obs, want); else n_pass++;
            cnt_want = (e < 12) ? 4'd0 : (e < 24) ? 4'd1 : (e >= 60 && e < 64) ? 4'd1 : 4'd2;
            n_checks++;
            if (active_cnt2 !== cnt_want || expired2 !== (e == 60) || $countones(map2) != int'(cnt_want))
                $display("FAIL saturation e=%0d got cnt=%0d exp=%b want cnt=%0d", e, active_cnt2, expired2, cnt_want);
            else n_pass++;
        end
        enable2 = 1'b0;
    endtask

    task automatic test_hit_vs_expiry();
        logic [16:0] obs, want; bit ok;
        int h = -1;
        for (int n = 0; n < 200 && h < 0; n++) begin
            if (m_tick == TD - 1)
                for (int i = 0; i < 9; i++) if (h < 0 && m_map[i] && m_life[i] == LT - 1) h = i;
            if (h < 0) step(obs, want, ok);
        end
        n_checks++;
        if (h < 0) begin
            $display("FAIL hit_vs_expiry_timeout got=none want=expiring mole");
        end else begin
            hit_valid = 1'b1; hit_idx = 4'(h);
            step(obs, want, ok);
            hit_valid = 1'b0;
            if (obs[13] !== 1'b1 || obs[15] !== 1'b0 || obs[h] !== 1'b0 || !ok || obs !== want)
                $display("FAIL hit_vs_expiry hole=%0d got=%h want=%h", h, obs, want);
            else n_pass++;
        end
    endtask

    task automatic test_disable();
        logic [16:0] obs, want; bit ok;
        int h = -1;
        for (int n = 0; n < 200 && popc(m_map) != 2; n++) step(obs, want, ok);
        for (int i = 0; i < 9; i++) if (h < 0 && m_map[i]) h = i;
        n_checks++;
        if (popc(m_map) != 2) begin
            $display("FAIL disable_timeout got=%0d moles want=2", popc(m_map));
        end else begin
            enable = 1'b0; hit_valid = 1'b1; hit_idx = 4'(h);
            step(obs, want, ok);
            hit_valid = 1'b0;
            if (obs !== 17'h0 || !ok || obs !== want)
                $display("FAIL disable got=%h want=0", obs);
            else n_pass++;
        end
    endtask

    task automatic test_async_reset();
        logic [16:0] obs, want; bit ok;
        enable = 1'b1;
        for (int k = 0; k < 40; k++) begin
            step(obs, want, ok);
            n_checks++;
            if (!ok || obs !== want) $display("FAIL rerun_sb k=%0d got=%h want=%h", k, obs, want); else n_pass++;
        end
        n_checks++;
        if (obs[16] !== 1'b1) $display("FAIL pre_reset_state got=%b want=1", obs[16]); else n_pass++;
        #3 rst = 1'b0;
        #1;
        n_checks++;
        if ({state, expired, hit_bad, hit_ok, active_cnt, map} !== 17'h0)
            $display("FAIL async_reset got=%h want=0", {state, expired, hit_bad, hit_ok, active_cnt, map});
        else n_pass++;
        enable = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        test_reset();
        test_spawn();
        test_expiry();
        test_hit();
        test_saturation();
        test_hit_vs_expiry();
        test_disable();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end
endmodule
